// File: rtl/cvxif_result_buffer_if.sv
// Result channel from the coprocessor and writeback channel to the core, bundled
// so the buffer and its environment share one set of signal declarations.
interface cvxif_result_buffer_if #(
    parameter int XLEN     = 64,
    parameter int ID_WIDTH = 4
) ();
    // Both channels: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits for ready, and the sender holds its payload stable until the transfer.
    logic                x_result_valid_i;
    logic                x_result_ready_o;
    logic [ID_WIDTH-1:0] x_result_id_i;
    logic [XLEN-1:0]     x_result_data_i;
    logic [4:0]          x_result_rd_i;
    logic                x_result_we_i;
    logic                x_result_exc_i;
    logic [5:0]          x_result_exccode_i;

    logic                wb_valid_o;
    logic                wb_ready_i;
    logic [ID_WIDTH-1:0] wb_id_o;
    logic [XLEN-1:0]     wb_data_o;
    logic [4:0]          wb_rd_o;
    logic                wb_we_o;
    logic                wb_exc_o;
    logic [5:0]          wb_exccode_o;

    modport master (
        output x_result_valid_i, x_result_id_i, x_result_data_i, x_result_rd_i,
               x_result_we_i, x_result_exc_i, x_result_exccode_i, wb_ready_i,
        input  x_result_ready_o, wb_valid_o, wb_id_o, wb_data_o, wb_rd_o,
               wb_we_o, wb_exc_o, wb_exccode_o
    );

    modport slave (
        input  x_result_valid_i, x_result_id_i, x_result_data_i, x_result_rd_i,
               x_result_we_i, x_result_exc_i, x_result_exccode_i, wb_ready_i,
        output x_result_ready_o, wb_valid_o, wb_id_o, wb_data_o, wb_rd_o,
               wb_we_o, wb_exc_o, wb_exccode_o
    );
endinterface

// File: rtl/cvxif_result_buffer.sv
// In-order result buffer between a CV-X-IF coprocessor and core writeback:
// a circular FIFO with no fall-through and no full-bypass, flushable in one cycle.
module cvxif_result_buffer #(
    parameter  int DEPTH    = 4,
    parameter  int XLEN     = 64,
    parameter  int ID_WIDTH = 4,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    cvxif_result_buffer_if.slave    bus,
    output logic [CNT_W-1:0]        count_o
);
    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [XLEN-1:0]     data;
        logic [4:0]          rd;
        logic                we;
        logic                exc;
        logic [5:0]          exccode;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           wr_entry;
    entry_t           head;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;

    // Ready ignores a same-cycle pop so the accept path never depends on wb_ready_i.
    assign bus.x_result_ready_o = (count_q < DEPTH_C) && !flush_i;
    assign bus.wb_valid_o       = (count_q != '0);

    assign push = bus.x_result_valid_i && bus.x_result_ready_o && !flush_i;
    assign pop  = bus.wb_valid_o && bus.wb_ready_i && !flush_i;

    // An excepting result must never write the register file; its code is zeroed otherwise.
    always_comb begin
        wr_entry         = '0;
        wr_entry.id      = bus.x_result_id_i;
        wr_entry.data    = bus.x_result_data_i;
        wr_entry.rd      = bus.x_result_rd_i;
        wr_entry.we      = bus.x_result_we_i && !bus.x_result_exc_i;
        wr_entry.exc     = bus.x_result_exc_i;
        wr_entry.exccode = bus.x_result_exc_i ? bus.x_result_exccode_i : 6'd0;
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    // DEPTH is a power of two, so pointer increments wrap DEPTH-1 -> 0 naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head             = mem[rd_ptr_q];
    assign bus.wb_id_o      = head.id;
    assign bus.wb_data_o    = head.data;
    assign bus.wb_rd_o      = head.rd;
    assign bus.wb_we_o      = head.we;
    assign bus.wb_exc_o     = head.exc;
    assign bus.wb_exccode_o = head.exccode;
    assign count_o          = count_q;
endmodule

// File: tb/tb_cvxif_result_buffer.sv
// Randomized scoreboard bench for cvxif_result_buffer: a queue-based occupancy
// model predicts acceptance, a negedge monitor checks every output against it.
module tb_cvxif_result_buffer;
  localparam int DEPTH = 4;
  localparam int XLEN = 64;
  localparam int IDW = 4;
  localparam int W = IDW + XLEN + 5 + 1 + 1 + 6;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic flush_i;
  logic [2:0] count_o;

  cvxif_result_buffer_if #(.XLEN(XLEN), .ID_WIDTH(IDW)) bus ();

  cvxif_result_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .ID_WIDTH(IDW)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .bus     (bus.slave),
    .count_o (count_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int model_cnt = 0;
  int n_vec = 0;
  int n_fail = 0;
  logic last_push;
  logic prev_hold = 1'b0;
  logic [W-1:0] prev_act;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic set_idle();
    bus.x_result_valid_i = 1'b0;
    bus.x_result_id_i = '0;
    bus.x_result_data_i = '0;
    bus.x_result_rd_i = '0;
    bus.x_result_we_i = 1'b0;
    bus.x_result_exc_i = 1'b0;
    bus.x_result_exccode_i = '0;
    bus.wb_ready_i = 1'b0;
    flush_i = 1'b0;
  endtask

  // Drives one cycle of inputs, then applies the reference rules for that edge.
  task automatic step(input logic v, input logic [IDW-1:0] id, input logic [XLEN-1:0] d,
                      input logic [4:0] rd, input logic we, input logic exc,
                      input logic [5:0] ec, input logic rdy, input logic fl);
    logic do_push;
    logic do_pop;
    bus.x_result_valid_i = v;
    bus.x_result_id_i = id;
    bus.x_result_data_i = d;
    bus.x_result_rd_i = rd;
    bus.x_result_we_i = we;
    bus.x_result_exc_i = exc;
    bus.x_result_exccode_i = ec;
    bus.wb_ready_i = rdy;
    flush_i = fl;
    @(posedge clk_i);
    #1;
    do_push = 1'b0;
    if (fl) begin
      exp_q.delete();
      model_cnt = 0;
    end else begin
      do_push = v && (model_cnt < DEPTH);
      do_pop = (model_cnt != 0) && rdy;
      if (do_push) exp_q.push_back({id, d, rd, we && !exc, exc, exc ? ec : 6'd0});
      model_cnt = model_cnt + int'(do_push) - int'(do_pop);
    end
    last_push = do_push;
  endtask

  task automatic idle_step(input logic rdy);
    step(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, rdy, 1'b0);
  endtask

  task automatic push_simple(input logic [IDW-1:0] id, input logic rdy);
    step(1'b1, id, {$urandom, $urandom}, 5'($urandom), 1'b1, 1'b0, '0, rdy, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) idle_step(1'b1);
    chk("drained_count", count_o, 0);
  endtask

  // Called just after a step; pulses reset between clock edges.
  task automatic reset_pulse();
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_count", count_o, 0);
    chk("rst_wb_valid", bus.wb_valid_o, 0);
    chk("rst_ready", bus.x_result_ready_o, 1);
    exp_q.delete();
    model_cnt = 0;
    set_idle();
    #3 rst_ni = 1'b1;
  endtask

  // monitor: checks every cycle, pops the scoreboard on each writeback transfer
  always @(negedge clk_i) begin
    logic [W-1:0] act;
    act = {bus.wb_id_o, bus.wb_data_o, bus.wb_rd_o, bus.wb_we_o, bus.wb_exc_o, bus.wb_exccode_o};
    chk("count", count_o, model_cnt);
    chk("ready", bus.x_result_ready_o, (model_cnt < DEPTH) && !flush_i);
    chk("wb_valid", bus.wb_valid_o, model_cnt != 0);
    if (prev_hold && bus.wb_valid_o) chk("hold_stable", act, prev_act);
    if (bus.wb_valid_o && bus.wb_ready_i && !flush_i && rst_ni) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL wb_underflow: got entry 0x%0h, expected no transfer", act);
      end else begin
        chk("wb_entry", act, exp_q.pop_front());
      end
    end
    prev_hold = bus.wb_valid_o && !bus.wb_ready_i && !flush_i && rst_ni;
    prev_act = act;
  end

  // stimulus
  initial begin
    rst_ni = 1'b0;
    set_idle();
    #3;
    chk("init_count", count_o, 0);
    chk("init_wb_valid", bus.wb_valid_o, 0);
    chk("init_ready", bus.x_result_ready_o, 1);
    #9 rst_ni = 1'b1;

    // single push, one cycle latency, then empty again
    step(1'b1, 4'd3, 64'h2A, 5'd5, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0);
    chk("single_valid", bus.wb_valid_o, 1);
    chk("single_id", bus.wb_id_o, 3);
    chk("single_data", bus.wb_data_o, 64'h2A);
    chk("single_rd", bus.wb_rd_o, 5);
    chk("single_we", bus.wb_we_o, 1);
    idle_step(1'b1);
    chk("single_empty", count_o, 0);

    // fill to full, hold a fifth result, then release
    for (int i = 0; i < 4; i++) push_simple(IDW'(i), 1'b0);
    chk("full_count", count_o, 4);
    chk("full_ready", bus.x_result_ready_o, 0);
    for (int i = 0; i < 2; i++) push_simple(4'd4, 1'b0);
    chk("full_hold_count", count_o, 4);
    begin
      int tries = 0;
      do begin
        step(1'b1, 4'd4, 64'h44, 5'd4, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0);
        tries++;
      end while (!last_push && tries < 10);
      chk("held_accepted", last_push, 1);
    end
    drain();

    // steady push+pop at count 2 across pointer wrap
    for (int i = 0; i < 2; i++) push_simple(IDW'(8 + i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      push_simple(IDW'(i), 1'b1);
      chk("stream_count", count_o, 2);
    end
    drain();

    // exception masks write enable and keeps its code
    step(1'b1, 4'd7, 64'h1234, 5'd9, 1'b1, 1'b1, 6'd5, 1'b0, 1'b0);
    chk("exc_flag", bus.wb_exc_o, 1);
    chk("exc_code", bus.wb_exccode_o, 5);
    chk("exc_we", bus.wb_we_o, 0);
    drain();

    // flush with concurrent push and pop
    for (int i = 0; i < 3; i++) push_simple(IDW'(i), 1'b0);
    step(1'b1, 4'hF, 64'hDEAD, 5'd1, 1'b1, 1'b0, 6'd0, 1'b1, 1'b1);
    chk("flush_count", count_o, 0);
    chk("flush_wb_valid", bus.wb_valid_o, 0);
    idle_step(1'b1);
    chk("flush_not_stored", count_o, 0);

    // asynchronous reset mid-operation
    for (int i = 0; i < 2; i++) push_simple(IDW'(i), 1'b0);
    reset_pulse();
    push_simple(4'd6, 1'b0);
    chk("post_rst_id", bus.wb_id_o, 6);
    drain();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic exc;
      exc = ($urandom_range(0, 7) == 0);
      step($urandom_range(0, 9) < 7, IDW'($urandom), {$urandom, $urandom}, 5'($urandom),
           1'($urandom), exc, 6'($urandom), $urandom_range(0, 9) < 6,
           $urandom_range(0, 49) == 0);
      if (i % 700 == 699) reset_pulse();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
